// File: rtl/mario_snd_pkg.sv
// Shared constants for the main-CPU sound command path: control latch bit map and FSM encoding.
package mario_snd_pkg;

    localparam int unsigned CTRL_IRQ   = 0;
    localparam int unsigned CTRL_T0    = 1;
    localparam int unsigned CTRL_T1    = 2;
    localparam int unsigned CTRL_P1_LO = 3;
    localparam int unsigned CTRL_P1_HI = 6;

    typedef logic [1:0] snd_state_t;

    localparam snd_state_t ST_IDLE    = 2'd0;
    localparam snd_state_t ST_LOAD    = 2'd1;
    localparam snd_state_t ST_IRQ_ON  = 2'd2;
    localparam snd_state_t ST_RELEASE = 2'd3;

endpackage

// File: rtl/snd_cmd_fifo.sv
// Small synchronous command FIFO; pushes into a full FIFO are rejected.
module snd_cmd_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo the depth on their own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mario_sound_cmd_tx.sv
// Main-CPU sound command transmitter: latches CPU writes, queues command bytes and hands
// them one at a time to the sound sub-CPU with an IRQ, waiting for its read ack or a timeout.
module mario_sound_cmd_tx
    import mario_snd_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 2,
    parameter int unsigned IRQ_TIMEOUT = 24000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               I_CLK_24M,
    input  logic               I_RST,
    input  logic               I_CPU_WRn,
    input  logic               I_CS_DATAn,
    input  logic               I_CS_CTRLn,
    input  logic [2:0]         I_CPU_A,
    input  logic [7:0]         I_CPU_D,
    input  logic               I_SUB_RDn,
    input  logic               I_SUB_P2_7,
    output logic [7:0]         O_SND_DATA,
    output logic [6:0]         O_SND_CTRL,
    output logic [FIFO_AW:0]   O_FIFO_CNT,
    output logic               O_OVF,
    output logic               O_TMO
);

    localparam int unsigned TW = $clog2(IRQ_TIMEOUT + 1);

    logic                         r_wr_low;
    logic                         r_cs_data;
    logic                         r_cs_ctrl;
    logic [2:0]                   r_a;
    logic [7:0]                   r_d;
    logic [CTRL_P1_HI:CTRL_T0]    r_ctrl;
    logic [SYNC_STAGES-1:0]       r_ack_sync;
    logic                         r_ack_prev;
    snd_state_t                   r_state;
    snd_state_t                   w_state_nxt;
    logic [TW-1:0]                r_tmo_cnt;
    logic [7:0]                   r_snd_data;
    logic                         r_ovf;
    logic                         r_tmo;

    logic                         w_wr_evt;
    logic                         w_data_wr;
    logic                         w_ctrl_wr;
    logic                         w_ack_raw;
    logic                         w_ack_sync;
    logic                         w_ack_evt;
    logic                         w_pop;
    logic                         w_tmo_set;
    logic                         w_full;
    logic                         w_empty;
    logic [7:0]                   w_fifo_head;

    // Bus values are sampled every low cycle; the event uses the last low-cycle sample.
    always_ff @(posedge I_CLK_24M or negedge I_RST) begin
        if (!I_RST) begin
            r_wr_low  <= 1'b0;
            r_cs_data <= 1'b1;
            r_cs_ctrl <= 1'b1;
            r_a       <= '0;
            r_d       <= '0;
        end else begin
            r_wr_low <= ~I_CPU_WRn;
            if (!I_CPU_WRn) begin
                r_cs_data <= I_CS_DATAn;
                r_cs_ctrl <= I_CS_CTRLn;
                r_a       <= I_CPU_A;
                r_d       <= I_CPU_D;
            end
        end
    end

    assign w_wr_evt  = r_wr_low & I_CPU_WRn;
    assign w_data_wr = w_wr_evt & ~r_cs_data;
    assign w_ctrl_wr = w_wr_evt & ~r_cs_ctrl & r_cs_data;

    always_ff @(posedge I_CLK_24M or negedge I_RST) begin
        if (!I_RST) begin
            r_ctrl <= '0;
        end else begin
            for (int i = CTRL_T0; i <= CTRL_P1_HI; i++) begin
                if (w_ctrl_wr && (r_a == 3'(i))) begin
                    r_ctrl[i] <= r_d[0];
                end
            end
        end
    end

    assign w_ack_raw  = ~I_SUB_RDn & I_SUB_P2_7;
    assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
    assign w_ack_evt  = w_ack_sync & ~r_ack_prev;

    always_ff @(posedge I_CLK_24M or negedge I_RST) begin
        if (!I_RST) begin
            r_ack_sync <= '0;
            r_ack_prev <= 1'b0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], w_ack_raw};
            r_ack_prev <= w_ack_sync;
        end
    end

    snd_cmd_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_fifo (
        .i_clk   (I_CLK_24M),
        .i_rst_n (I_RST),
        .i_push  (w_data_wr),
        .i_data  (r_d),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (O_FIFO_CNT)
    );

    // An ack arriving on the timeout cycle takes priority, so no timeout is flagged.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tmo_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = ST_IRQ_ON;
            end
            ST_IRQ_ON: begin
                if (w_ack_evt) begin
                    w_state_nxt = ST_RELEASE;
                end else if (r_tmo_cnt == TW'(IRQ_TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_tmo_set   = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!w_ack_sync) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK_24M or negedge I_RST) begin
        if (!I_RST) begin
            r_state    <= ST_IDLE;
            r_tmo_cnt  <= '0;
            r_snd_data <= '0;
            r_ovf      <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_snd_data <= w_fifo_head;
                r_tmo_cnt  <= '0;
            end else if (r_state == ST_IRQ_ON) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            r_ovf <= r_ovf | (w_data_wr & w_full);
            r_tmo <= r_tmo | w_tmo_set;
        end
    end

    assign O_SND_DATA = r_snd_data;
    assign O_SND_CTRL = {r_ctrl, (r_state == ST_IRQ_ON)};
    assign O_OVF      = r_ovf;
    assign O_TMO      = r_tmo;

endmodule

// File: tb/tb_mario_sound_cmd_tx.sv
// Directed and randomized bench for mario_sound_cmd_tx against a queue-based command model.
module tb_mario_sound_cmd_tx;

    localparam int unsigned FIFO_AW     = 2;
    localparam int unsigned IRQ_TIMEOUT = 24000;
    localparam int unsigned SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cpu_wrn;
    logic             cs_datan;
    logic             cs_ctrln;
    logic [2:0]       cpu_a;
    logic [7:0]       cpu_d;
    logic             sub_rdn;
    logic             sub_p27;
    logic [7:0]       snd_data;
    logic [6:0]       snd_ctrl;
    logic [FIFO_AW:0] fifo_cnt;
    logic             ovf;
    logic             tmo;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model: control latch image and every byte written but not yet acked, oldest first.
    logic [6:0]       m_ctrl;
    logic [7:0]       mq[$];

    always #5 clk = ~clk;

    mario_sound_cmd_tx #(
        .FIFO_AW     (FIFO_AW),
        .IRQ_TIMEOUT (IRQ_TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .I_CLK_24M  (clk),
        .I_RST      (rst_n),
        .I_CPU_WRn  (cpu_wrn),
        .I_CS_DATAn (cs_datan),
        .I_CS_CTRLn (cs_ctrln),
        .I_CPU_A    (cpu_a),
        .I_CPU_D    (cpu_d),
        .I_SUB_RDn  (sub_rdn),
        .I_SUB_P2_7 (sub_p27),
        .O_SND_DATA (snd_data),
        .O_SND_CTRL (snd_ctrl),
        .O_FIFO_CNT (fifo_cnt),
        .O_OVF      (ovf),
        .O_TMO      (tmo)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic dsel, input logic csel, input logic [2:0] a,
                          input logic [7:0] d);
        cpu_wrn  = 1'b0;
        cs_datan = ~dsel;
        cs_ctrln = ~csel;
        cpu_a    = a;
        cpu_d    = d;
        cyc(1);
        cpu_wrn  = 1'b1;
        cs_datan = 1'b1;
        cs_ctrln = 1'b1;
        cpu_a    = 3'($urandom);
        cpu_d    = 8'($urandom);
        cyc(1);
    endtask

    task automatic wait_irq(input logic lvl, input int bound, input string tag);
        int n;
        n = 0;
        while (snd_ctrl[0] !== lvl && n < bound) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(snd_ctrl[0]), 32'(lvl));
    endtask

    task automatic serve(input string tag);
        logic [7:0] e;
        wait_irq(1'b1, 20, {tag, "_irq"});
        e = mq.pop_front();
        chk({tag, "_data"}, 32'(snd_data), 32'(e));
        sub_rdn = 1'b0;
        sub_p27 = 1'b1;
        wait_irq(1'b0, SYNC_STAGES + 2, {tag, "_ack"});
        sub_rdn = 1'b1;
        sub_p27 = 1'b0;
        cyc(SYNC_STAGES + 2);
    endtask

    initial begin
        int n;
        int op;
        logic [2:0] a;
        logic [7:0] d;
        logic both;

        rst_n    = 1'b0;
        cpu_wrn  = 1'b1;
        cs_datan = 1'b1;
        cs_ctrln = 1'b1;
        cpu_a    = '0;
        cpu_d    = '0;
        sub_rdn  = 1'b1;
        sub_p27  = 1'b0;
        m_ctrl   = '0;
        cyc(3);
        chk("rst_data", 32'(snd_data), 32'h0);
        chk("rst_ctrl", 32'(snd_ctrl), 32'h0);
        chk("rst_cnt", 32'(fifo_cnt), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Single write: IRQ and data appear on the third edge after WRn rises.
        cpu_wr(1'b1, 1'b0, 3'd0, 8'h5A);
        chk("single_cnt", 32'(fifo_cnt), 32'd1);
        chk("single_irq_n1", 32'(snd_ctrl[0]), 32'd0);
        cyc(1);
        chk("single_irq_n2", 32'(snd_ctrl[0]), 32'd0);
        cyc(1);
        chk("single_irq_n3", 32'(snd_ctrl[0]), 32'd1);
        chk("single_data", 32'(snd_data), 32'h5A);
        sub_rdn = 1'b0;
        sub_p27 = 1'b1;
        wait_irq(1'b0, SYNC_STAGES + 2, "single_ack");
        sub_rdn = 1'b1;
        sub_p27 = 1'b0;
        cyc(SYNC_STAGES + 3);
        chk("single_idle_irq", 32'(snd_ctrl[0]), 32'd0);
        chk("single_idle_cnt", 32'(fifo_cnt), 32'd0);
        chk("single_hold_data", 32'(snd_data), 32'h5A);

        // Control latch directed writes.
        cpu_wr(1'b0, 1'b1, 3'd1, 8'h01);
        chk("ctrl_a1_set", 32'(snd_ctrl), 32'b0000010);
        cpu_wr(1'b0, 1'b1, 3'd5, 8'h01);
        chk("ctrl_a5_set", 32'(snd_ctrl), 32'b0100010);
        cpu_wr(1'b0, 1'b1, 3'd0, 8'h01);
        cyc(3);
        chk("ctrl_a0_ignored", 32'(snd_ctrl), 32'b0100010);
        cpu_wr(1'b0, 1'b1, 3'd7, 8'hFF);
        chk("ctrl_a7_ignored", 32'(snd_ctrl), 32'b0100010);
        cpu_wr(1'b0, 1'b1, 3'd1, 8'hFE);
        chk("ctrl_a1_clr", 32'(snd_ctrl), 32'b0100000);
        m_ctrl = 7'b0100000;

        // Randomized mix of control writes, data writes and sub-CPU service.
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 2));
            a  = 3'($urandom);
            d  = 8'($urandom);
            if (op == 0) begin
                cpu_wr(1'b0, 1'b1, a, d);
                if (a >= 3'd1 && a <= 3'd6) m_ctrl[a] = d[0];
                chk("rnd_ctrl", 32'(snd_ctrl[6:1]), 32'(m_ctrl[6:1]));
            end else if (op == 1 && mq.size() < 4) begin
                both = 1'($urandom_range(0, 1));
                cpu_wr(1'b1, both, a, d);
                mq.push_back(d);
                cyc(3);
                chk("rnd_cnt", 32'(fifo_cnt), 32'(mq.size() - 1));
                chk("rnd_irq", 32'(snd_ctrl[0]), 32'd1);
                chk("rnd_ctrl_kept", 32'(snd_ctrl[6:1]), 32'(m_ctrl[6:1]));
            end else if (mq.size() > 0) begin
                serve("rnd");
            end
        end
        while (mq.size() > 0) serve("drain");
        chk("drain_cnt", 32'(fifo_cnt), 32'd0);

        // Ack lands on the very cycle the timeout would fire.
        cpu_wr(1'b1, 1'b0, 3'd0, 8'hC3);
        cyc(2);
        chk("race_irq_on", 32'(snd_ctrl[0]), 32'd1);
        cyc(IRQ_TIMEOUT - 1 - SYNC_STAGES);
        sub_rdn = 1'b0;
        sub_p27 = 1'b1;
        cyc(SYNC_STAGES);
        chk("race_irq_last", 32'(snd_ctrl[0]), 32'd1);
        cyc(1);
        chk("race_irq_off", 32'(snd_ctrl[0]), 32'd0);
        chk("race_tmo", 32'(tmo), 32'd0);
        cpu_wr(1'b1, 1'b0, 3'd0, 8'h77);
        mq.push_back(8'h77);
        cyc(4);
        chk("race_release_hold", 32'(snd_ctrl[0]), 32'd0);
        sub_rdn = 1'b1;
        sub_p27 = 1'b0;
        serve("race_next");

        // Burst of six writes with no ack: first is presented, four buffered, last dropped.
        for (int v = 1; v <= 6; v++) cpu_wr(1'b1, 1'b0, 3'd0, 8'(v));
        cyc(2);
        chk("burst_cnt", 32'(fifo_cnt), 32'd4);
        chk("burst_ovf", 32'(ovf), 32'd1);
        chk("burst_data", 32'(snd_data), 32'h01);
        for (int v = 1; v <= 5; v++) mq.push_back(8'(v));
        while (mq.size() > 0) serve("burst");
        chk("burst_empty", 32'(fifo_cnt), 32'd0);

        // Timeout: IRQ held for exactly IRQ_TIMEOUT cycles.
        cpu_wr(1'b1, 1'b0, 3'd0, 8'h33);
        cyc(2);
        n = 0;
        while (snd_ctrl[0] === 1'b1 && n < int'(IRQ_TIMEOUT) + 100) begin
            n++;
            cyc(1);
        end
        chk("tmo_len", 32'(n), 32'(IRQ_TIMEOUT));
        chk("tmo_flag", 32'(tmo), 32'd1);
        chk("tmo_data", 32'(snd_data), 32'h33);
        chk("tmo_ovf_sticky", 32'(ovf), 32'd1);

        // Reset during IRQ with three bytes queued.
        cpu_wr(1'b0, 1'b1, 3'd3, 8'h01);
        for (int v = 0; v < 4; v++) cpu_wr(1'b1, 1'b0, 3'd0, 8'(8'h41 + v));
        cyc(2);
        chk("mid_cnt", 32'(fifo_cnt), 32'd3);
        chk("mid_irq", 32'(snd_ctrl[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(snd_data), 32'h0);
        chk("mid_rst_ctrl", 32'(snd_ctrl), 32'h0);
        chk("mid_rst_cnt", 32'(fifo_cnt), 32'h0);
        chk("mid_rst_ovf", 32'(ovf), 32'h0);
        chk("mid_rst_tmo", 32'(tmo), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(8);
        chk("post_rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("post_rst_irq", 32'(snd_ctrl[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
